pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//   Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle)
//   and drives 16 digital outputs: uo_out[7:0] = out[7:0], uio_out[7:0] = out[15:8].
//   Each output is forced low, held static high, or driven by a shared 8-bit PWM waveform (~3 kHz @ 10 MHz clk).
// PARAMETERS
//   CLK_DIV    13   clk cycles per PWM counter step; period = CLK_DIV*256 clk cycles (>=1)
//   DIV_W      8    prescaler width; must satisfy 2**DIV_W >= CLK_DIV
// PORTS
//   clk              in   1  system clock, sole clock domain
//   rst_n            in   1  asynchronous active-low reset
//   en_reg_out_7_0   in   8  output enable, bits 7:0   (1 = output active)
//   en_reg_out_15_8  in   8  output enable, bits 15:8
//   en_reg_pwm_7_0   in   8  PWM mode select, bits 7:0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  in   8  PWM mode select, bits 15:8
//   pwm_duty_cycle   in   8  duty, high time = duty/256 of period; 8'hFF = 100%
//   out              out  16 registered output pins
//   pwm_sync         out  1  one-clk pulse on the first clk of every PWM period
// BEHAVIOUR
//   Reset (async assert, sync release): out=16'h0, pwm_sync=0, prescaler=0, pwm_cnt=0, duty_act=0.
//   Prescaler: counts 0..CLK_DIV-1, wraps to 0; step = (prescaler==CLK_DIV-1). CLK_DIV=1 -> step every clk.
//   pwm_cnt: 8-bit, increments on step, wraps 255->0 (no hold, no saturation).
//   period_end = step && pwm_cnt==8'hFF; pwm_sync registered from period_end (high while pwm_cnt==0, prescaler==0).
//   Compare: pwm_sig = (duty_act==8'hFF) ? 1 : (pwm_cnt < duty_act). duty 0 -> never high; 8'h80 -> 128/256 high.
//   Per bit i: next_out[i] = en_out[i] ? (en_pwm[i] ? pwm_sig : 1'b1) : 1'b0; en_out has priority over en_pwm.
//   out is registered from next_out: exactly 1 clk latency from pwm_cnt/enable change to pin.
//   Enable registers are not shadowed: a change is visible on out on the following clk, mid-period allowed.
//   Inputs are already in the clk domain (SPI block synchronises); no extra synchronisers here.
//   Simultaneous duty change and period_end: new duty is the one captured (see CONFIGURATION).
//   Reset mid-period: all outputs low immediately; after release, first period starts at pwm_cnt=0.
// CONFIGURATION
//   Macro PWM_DUTY_SHADOW_EN:
//     defined: duty_act is a register loaded from pwm_duty_cycle only on period_end (and resets to 0);
//              a duty write never truncates or lengthens the current period's high pulse (glitch-free).
//              After reset, duty_act stays 0 until the first period_end.
//     undefined: duty_act = pwm_duty_cycle combinationally; new duty applies on the next clk, mid-period.
// STRUCTURE
//   Shared package/header pwm_defs: PWM_RES=8, PWM_DUTY_FULL=8'hFF, CLK_DIV default,
//     SPI register addresses (0x00 en_out_lo, 0x01 en_out_hi, 0x02 en_pwm_lo, 0x03 en_pwm_hi, 0x04 duty),
//     shared with spi_peripheral so the register map has a single definition.
//   Sub-module pwm_timebase: prescaler + pwm_cnt + period_end/pwm_sync; top does shadow, compare, output mux.
// TESTING
//   1 Reset: hold rst_n=0 with all enables 8'hFF, duty 8'h80 -> out==0, pwm_sync==0; release -> pwm_sync first at clk CLK_DIV*256.
//   2 Static: en_out=16'h00FF, en_pwm=0 -> out==16'h00FF one clk after write, constant over 3 periods.
//   3 Duty: en_out=en_pwm=16'hFFFF, duty 8'h40 -> each bit high 64*CLK_DIV clks of 3328, period 3328 clks exactly.
//   4 Extremes: duty 8'h00 -> out stays 0 for full period; duty 8'hFF -> out stays 16'hFFFF, no 1-clk dip at wrap.
//   5 Mask: en_out=16'hA5A5, en_pwm=16'h0F0F, duty 8'h80 -> bits with en_out=0 low; pwm bits toggle; others high.
//   6 Shadow (macro on): change duty 8'h20->8'hE0 at pwm_cnt=8'h10 -> current period high 32 steps, next 224;
//     macro off -> same stimulus gives high until pwm_cnt reaches 8'hE0 in the current period.

Source files
------------

// File: rtl/pwm_peripheral_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_peripheral_pkg
// Purpose : Shared PWM definitions. These are the resolution, the full-duty
//           code and the default timebase. It also holds the SPI register map
//           that spi_peripheral uses, so the map is defined in one place only.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package pwm_peripheral_pkg;

    localparam int         PWM_RES         = 8;
    localparam logic [7:0] PWM_DUTY_FULL   = 8'hFF;
    localparam int         CLK_DIV_DEFAULT = 13;
    localparam int         DIV_W_DEFAULT   = 8;

    // SPI register addresses, shared with spi_peripheral
    typedef enum logic [7:0] {
        REG_EN_OUT_LO = 8'h00,
        REG_EN_OUT_HI = 8'h01,
        REG_EN_PWM_LO = 8'h02,
        REG_EN_PWM_HI = 8'h03,
        REG_DUTY      = 8'h04
    } pwm_reg_addr_e;

    // Per-pin select. A disabled pin is low. An enabled static pin is high.
    // An enabled PWM pin follows the shared waveform.
    function automatic logic [15:0] pwm_pin_mux(input logic [15:0] en_out,
                                                input logic [15:0] en_pwm,
                                                input logic        pwm_sig);
        return en_out & (~en_pwm | {16{pwm_sig}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module  : pwm_peripheral_if
// Purpose : Control register bundle written over SPI and consumed by the PWM.
// Ports   : en_reg_out_7_0 / en_reg_out_15_8 - output enables
//           en_reg_pwm_7_0 / en_reg_pwm_15_8 - PWM (1) / static high (0)
//           pwm_duty_cycle                    - shared duty code
//           modport master: register file side; modport slave: PWM side
// Revision: 1.0 - initial release
// ============================================================================
interface pwm_peripheral_if;
    import pwm_peripheral_pkg::*;

    logic [PWM_RES-1:0] en_reg_out_7_0;
    logic [PWM_RES-1:0] en_reg_out_15_8;
    logic [PWM_RES-1:0] en_reg_pwm_7_0;
    logic [PWM_RES-1:0] en_reg_pwm_15_8;
    logic [PWM_RES-1:0] pwm_duty_cycle;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8,
        output en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8,
        input  en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle
    );

endinterface
`default_nettype wire

// File: rtl/pwm_peripheral_timebase.sv
`default_nettype none
// ============================================================================
// Module  : pwm_peripheral_timebase
// Purpose : Prescaler plus the 8-bit PWM counter. It produces a period-end
//           strobe and a registered one-clock sync pulse at each period start.
// Ports   : clk, rst_n (async active-low)
//           pwm_cnt    - current PWM step, 0..255, free-running wrap
//           period_end - high on the last clk of a period (combinational)
//           pwm_sync   - registered period_end, high on the first clk of a period
// Revision: 1.0 - initial release
// ============================================================================
module pwm_peripheral_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    output logic [PWM_RES-1:0]      pwm_cnt,
    output logic                    period_end,
    output logic                    pwm_sync
);

    localparam logic [DIV_W-1:0]   C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PWM_RES-1:0] C_CNT_LAST = '1;

    logic [DIV_W-1:0]   r_prescaler;
    logic [PWM_RES-1:0] r_pwm_cnt;
    logic               r_pwm_sync;
    logic               w_step;

    // With CLK_DIV == 1 the prescaler stays at 0 and every clk is a step
    assign w_step     = (r_prescaler == C_DIV_LAST);
    assign period_end = w_step && (r_pwm_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
            r_pwm_sync  <= 1'b0;
        end else begin
            r_prescaler <= w_step ? '0 : r_prescaler + DIV_W'(1);
            if (w_step) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_RES'(1);
            end
            r_pwm_sync  <= period_end;
        end
    end

    assign pwm_cnt  = r_pwm_cnt;
    assign pwm_sync = r_pwm_sync;

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : pwm_peripheral
// Purpose : Drives 16 pins from the SPI control registers. Each pin is forced
//           low, held static high, or driven by a shared 8-bit PWM waveform.
//           out[7:0] maps to uo_out and out[15:8] maps to uio_out.
// Ports   : clk, rst_n (async active-low)
//           regs     - control registers (pwm_peripheral_if.slave)
//           out      - registered pins, one clk after counter/enable change
//           pwm_sync - one-clk pulse on the first clk of each PWM period
// Config  : PWM_DUTY_SHADOW_EN - when defined, the duty code is captured only
//           at period end. A write can then never cut short or stretch the
//           pulse already in progress. When undefined, the duty code is used
//           straight from the register.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pwm_peripheral_if.slave   regs,
    output logic [15:0]       out,
    output logic              pwm_sync
);

    logic [PWM_RES-1:0] w_pwm_cnt;
    logic               w_period_end;
    logic [PWM_RES-1:0] w_duty_act;
    logic               w_pwm_sig;
    logic [15:0]        w_en_out;
    logic [15:0]        w_en_pwm;
    logic [15:0]        w_next_out;
    logic [15:0]        r_out;

    pwm_peripheral_timebase #(
        .CLK_DIV    (CLK_DIV),
        .DIV_W      (DIV_W)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_cnt    (w_pwm_cnt),
        .period_end (w_period_end),
        .pwm_sync   (pwm_sync)
    );

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_RES-1:0] r_duty_act;

    // Load at the period boundary, so the new duty starts exactly at pwm_cnt == 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_act <= '0;
        end else if (w_period_end) begin
            r_duty_act <= regs.pwm_duty_cycle;
        end
    end

    assign w_duty_act = r_duty_act;
`else
    // The period boundary is needed only to capture the duty code
    logic w_unused_period_end;
    assign w_unused_period_end = w_period_end;
    assign w_duty_act          = regs.pwm_duty_cycle;
`endif

    // The full-scale code means always high. Otherwise the step at cnt == 255
    // would make a one-clk dip at the wrap.
    assign w_pwm_sig  = (w_duty_act == PWM_DUTY_FULL) || (w_pwm_cnt < w_duty_act);

    assign w_en_out   = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
    assign w_en_pwm   = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
    assign w_next_out = pwm_pin_mux(w_en_out, w_en_pwm, w_pwm_sig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_next_out;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_peripheral
// Purpose : Self-checking bench for pwm_peripheral. A time-based reference
//           model tracks clocks since reset and works out each pin from the
//           duty and enable rules. Directed period measurements and
//           randomized register traffic are compared against it every clk.
// Config  : follows PWM_DUTY_SHADOW_EN like the design
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = CLK_DIV * 256;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] out;
    logic        pwm_sync;

    pwm_peripheral_if regs ();

    pwm_peripheral #(
        .CLK_DIV  (CLK_DIV),
        .DIV_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .regs     (regs),
        .out      (out),
        .pwm_sync (pwm_sync)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        regs.en_reg_out_7_0  = eo[7:0];
        regs.en_reg_out_15_8 = eo[15:8];
        regs.en_reg_pwm_7_0  = ep[7:0];
        regs.en_reg_pwm_15_8 = ep[15:8];
        regs.pwm_duty_cycle  = d;
    endtask

    // ---------------- reference model ----------------
    // n counts the clks since reset release. The PWM step in effect before
    // clk n+1 is floor(n / CLK_DIV) mod 256. A period starts every PERIOD clks.
    int          m_n;
    logic [15:0] m_out;
    logic        m_sync;
    logic [7:0]  m_duty_sh;

    function automatic logic [15:0] model_pins(input int n, input logic [7:0] d,
                                               input logic [15:0] eo, input logic [15:0] ep);
        int          step;
        logic        hi;
        logic [15:0] r;
        step = (n / CLK_DIV) % 256;
        hi   = (d == 8'hFF) || (step < int'(d));
        for (int i = 0; i < 16; i++) begin
            r[i] = eo[i] ? (ep[i] ? hi : 1'b1) : 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       <= 0;
            m_out     <= '0;
            m_sync    <= 1'b0;
            m_duty_sh <= '0;
        end else begin
            m_out  <= model_pins(m_n, SHADOW ? m_duty_sh : regs.pwm_duty_cycle,
                                 {regs.en_reg_out_15_8, regs.en_reg_out_7_0},
                                 {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0});
            m_n    <= m_n + 1;
            m_sync <= ((m_n + 1) % PERIOD) == 0;
            if (((m_n + 1) % PERIOD) == 0) begin
                m_duty_sh <= regs.pwm_duty_cycle;
            end
        end
    end

    // Compare process: outputs checked against the model on every negedge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_vs_model", {16'h0, out}, {16'h0, m_out});
            check("sync_vs_model", {31'h0, pwm_sync}, {31'h0, m_sync});
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_sync(output int clks);
        bit seen;
        seen = 1'b0;
        clks = 0;
        for (int k = 0; k < PERIOD + 32; k++) begin
            @(negedge clk);
            clks++;
            if (pwm_sync) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("sync_timeout", 32'd0, 32'd1);
    endtask

    // Window of PERIOD samples. With align set, sample j shows PWM step
    // floor(j / CLK_DIV) of the period. An optional duty write follows sample chg_at.
    task automatic measure(input bit align, input int chg_at, input logic [7:0] chg_duty,
                           output int all_hi, output int any_hi, output int syncs);
        int dummy;
        if (align) wait_sync(dummy);
        all_hi = 0;
        any_hi = 0;
        syncs  = 0;
        for (int j = 0; j < PERIOD; j++) begin
            @(negedge clk);
            if (out == 16'hFFFF) all_hi++;
            if (out != 16'h0000) any_hi++;
            if (pwm_sync) syncs++;
            if (j == chg_at) regs.pwm_duty_cycle = chg_duty;
        end
    endtask

    int a_hi, n_hi, s_cnt, clks, bad_lo, bad_hi, hi0;

    initial begin
        // 1 Reset held with everything enabled
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b1;
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_sync", {31'h0, pwm_sync}, 32'h0);
        rst_n = 1'b1;
        wait_sync(clks);
        check("first_sync_clk", clks, PERIOD);

        // 2 Static outputs
        @(negedge clk);
        set_regs(16'h00FF, 16'h0000, 8'h80);
        @(negedge clk);
        check("static_latency", {16'h0, out}, 32'h00FF);
        bad_lo = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            if (out != 16'h00FF) bad_lo++;
        end
        check("static_3_periods", bad_lo, 0);

        // 3 Duty 0x40
        set_regs(16'hFFFF, 16'hFFFF, 8'h40);
        measure(1'b1, -1, 8'h00, a_hi, n_hi, s_cnt);
        check("duty40_high", a_hi, 64 * CLK_DIV);
        check("duty40_any", n_hi, 64 * CLK_DIV);
        check("duty40_syncs", s_cnt, 1);
        wait_sync(clks);
        check("period_len", clks, PERIOD);

        // 4 Extremes
        regs.pwm_duty_cycle = 8'h00;
        measure(1'b1, -1, 8'h00, a_hi, n_hi, s_cnt);
        check("duty00_any", n_hi, 0);
        regs.pwm_duty_cycle = 8'hFF;
        measure(1'b1, -1, 8'h00, a_hi, n_hi, s_cnt);
        check("dutyFF_high", a_hi, PERIOD);
        measure(1'b0, -1, 8'h00, a_hi, n_hi, s_cnt);
        check("dutyFF_wrap", a_hi, PERIOD);

        // 5 Mask pattern
        set_regs(16'hA5A5, 16'h0F0F, 8'h80);
        wait_sync(clks);
        bad_lo = 0; bad_hi = 0; hi0 = 0;
        for (int j = 0; j < PERIOD; j++) begin
            @(negedge clk);
            if ((out & 16'h5A5A) != 16'h0) bad_lo++;
            if ((out & 16'hA0A0) != 16'hA0A0) bad_hi++;
            if (out[0]) hi0++;
        end
        check("mask_disabled_low", bad_lo, 0);
        check("mask_static_high", bad_hi, 0);
        check("mask_pwm_high", hi0, 128 * CLK_DIV);

        // 6 Duty write 0x20 -> 0xE0 at step 0x10
        set_regs(16'hFFFF, 16'hFFFF, 8'h20);
        measure(1'b1, 16 * CLK_DIV - 1, 8'hE0, a_hi, n_hi, s_cnt);
        check("dutychg_cur", a_hi, SHADOW ? 32 * CLK_DIV : 224 * CLK_DIV);
        measure(1'b0, -1, 8'h00, a_hi, n_hi, s_cnt);
        check("dutychg_next", a_hi, 224 * CLK_DIV);

        // Randomized register traffic, one mid-period reset
        for (int it = 0; it < 16; it++) begin
            set_regs(16'($urandom), 16'($urandom), 8'($urandom));
            repeat ($urandom_range(1, 1200)) @(negedge clk);
            if (it == 8) begin
                #3 rst_n = 1'b0;
                #1;
                check("async_reset_out", {16'h0, out}, 32'h0);
                check("async_reset_sync", {31'h0, pwm_sync}, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                wait_sync(clks);
                check("restart_sync_clk", clks, PERIOD);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
